// File: rtl/tail_light_pkg.sv
// tail_light_pkg: shared lamp-mode type and sequence-phase constants for the tail-light scheduler
package tail_light_pkg;
  typedef enum logic [1:0] {MODE_OFF, MODE_LEFT, MODE_RIGHT, MODE_HAZARD} mode_e;
  localparam int PHASE_W = 2;
  localparam logic [PHASE_W-1:0] PHASE_LAST = 2'd3;
endpackage

// File: rtl/tail_light_debounce.sv
// tail_light_debounce: 2-flop synchroniser plus debouncer; ports clk, rst_n (async active-low), i_raw (raw switch), o_level (accepted level)
module tail_light_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE);
  logic r_s0, r_s1, r_acc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign o_level = r_acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s0  <= 1'b0;
      r_s1  <= 1'b0;
      r_acc <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s0 <= i_raw;
      r_s1 <= r_s0;
      if (r_s1 == r_acc) r_cnt <= '0;
      else if (w_cnt_inc == LIM) begin
        r_acc <= r_s1;
        r_cnt <= '0;
      end else r_cnt <= w_cnt_inc;
    end
endmodule

// File: rtl/tail_light_mode_sched.sv
// tail_light_mode_sched: conditions lamp switches, arbitrates the lamp mode and steps a 4-phase sequence on a prescaled tick.
// Ports: clk, rst_n (async active-low), brake/turn_left/turn_right/hazard (raw switches),
//        mode (00 OFF, 01 LEFT, 10 RIGHT, 11 HAZARD), phase (0..3), step_tick, brake_active, busy.
// Build option HAZARD_EN: hazard input and left+right both map to HAZARD; otherwise hazard is ignored.
module tail_light_mode_sched
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV = 5,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       brake,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       hazard,
  output logic [1:0] mode,
  output logic [1:0] phase,
  output logic       step_tick,
  output logic       brake_active,
  output logic       busy
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TLAST = PW'(TICK_DIV - 1);
  logic w_brk, w_left, w_right;
  logic [PW-1:0] r_pre;
  logic r_tick, r_busy;
  mode_e r_mode, w_mode_nxt, w_req;
  logic [PHASE_W-1:0] r_phase, w_phase_nxt;
  tail_light_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_brake (.clk(clk), .rst_n(rst_n), .i_raw(brake), .o_level(w_brk));
  tail_light_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_left  (.clk(clk), .rst_n(rst_n), .i_raw(turn_left), .o_level(w_left));
  tail_light_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_right (.clk(clk), .rst_n(rst_n), .i_raw(turn_right), .o_level(w_right));
`ifdef HAZARD_EN
  logic w_haz;
  tail_light_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_haz (.clk(clk), .rst_n(rst_n), .i_raw(hazard), .o_level(w_haz));
  always_comb
    w_req = (w_haz || (w_left && w_right)) ? MODE_HAZARD :
            w_left ? MODE_LEFT : w_right ? MODE_RIGHT : MODE_OFF;
`else
  logic w_unused_hazard;
  assign w_unused_hazard = hazard;
  always_comb
    w_req = (w_left && !w_right) ? MODE_LEFT :
            (w_right && !w_left) ? MODE_RIGHT : MODE_OFF;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= (r_pre == TLAST) ? '0 : r_pre + PW'(1);
      r_tick <= (r_pre == TLAST);
    end
  // A new mode is only loaded from OFF or at the end of a sweep, so patterns are never cut short.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_phase_nxt = r_phase;
    if (r_tick) begin
      w_mode_nxt  = (r_mode == MODE_OFF || r_phase == PHASE_LAST) ? w_req : r_mode;
      w_phase_nxt = (r_mode == MODE_OFF || r_phase == PHASE_LAST) ? '0 : r_phase + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mode  <= MODE_OFF;
      r_phase <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_phase <= w_phase_nxt;
      r_busy  <= (w_mode_nxt != MODE_OFF);
    end
  assign mode         = r_mode;
  assign phase        = r_phase;
  assign step_tick    = r_tick;
  assign brake_active = w_brk;
  assign busy         = r_busy;
endmodule

// File: tb/tb_tail_light_mode_sched.sv
// tb_tail_light_mode_sched: directed self-checking bench for tail_light_mode_sched (TICK_DIV=5, DEBOUNCE=3)
module tb_tail_light_mode_sched;
  logic clk = 0, rst_n = 0, brake = 0, turn_left = 0, turn_right = 0, hazard = 0;
  logic [1:0] mode, phase;
  logic step_tick, brake_active, busy;
  int total = 0, bad = 0;
  tail_light_mode_sched #(.TICK_DIV(5), .DEBOUNCE(3)) dut (
    .clk(clk), .rst_n(rst_n), .brake(brake), .turn_left(turn_left), .turn_right(turn_right),
    .hazard(hazard), .mode(mode), .phase(phase), .step_tick(step_tick),
    .brake_active(brake_active), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick();
    for (int i = 0; i < 10 && step_tick !== 1'b1; i++) step();
  endtask
  task automatic tick_edge();
    wait_tick();
    step();
  endtask
  task automatic test_reset();
    logic exp;
    repeat (3) step();
    total++;
    if ({mode, phase, step_tick, brake_active, busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", {mode, phase, step_tick, brake_active, busy}, 7'b0);
    end
    rst_n = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i % 5 == 0);
      total++;
      if (step_tick !== exp) begin
        bad++;
        $display("FAIL tick_edge%0d got=%b exp=%b", i, step_tick, exp);
      end
    end
  endtask
  task automatic test_glitch();
    logic seen;
    seen = 0;
    wait_tick();
    turn_left = 1;
    step();
    step();
    turn_left = 0;
    repeat (15) begin
      step();
      if (mode !== 2'd0 || busy !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL glitch_reject got=mode%0d busy%0d exp=mode0 busy0", mode, busy);
    end
  endtask
  task automatic test_hold();
    wait_tick();
    turn_left = 1;
    repeat (5) step();
    total++;
    if (mode !== 2'd0) begin
      bad++;
      $display("FAIL hold_pre_mode got=%0d exp=0", mode);
    end
    step();
    total++;
    if ({mode, phase, busy} !== {2'd1, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL hold_start got=%b exp=%b", {mode, phase, busy}, {2'd1, 2'd0, 1'b1});
    end
    for (int p = 1; p <= 3; p++) begin
      repeat (5) step();
      total++;
      if (mode !== 2'd1 || phase !== 2'(p)) begin
        bad++;
        $display("FAIL hold_phase got=mode%0d phase%0d exp=mode1 phase%0d", mode, phase, p);
      end
    end
  endtask
  task automatic test_release();
    tick_edge();
    total++;
    if (mode !== 2'd1 || phase !== 2'd0) begin
      bad++;
      $display("FAIL sweep_repeat got=mode%0d phase%0d exp=mode1 phase0", mode, phase);
    end
    tick_edge();
    turn_left = 0;
    for (int p = 2; p <= 3; p++) begin
      tick_edge();
      total++;
      if (mode !== 2'd1 || phase !== 2'(p)) begin
        bad++;
        $display("FAIL release_phase got=mode%0d phase%0d exp=mode1 phase%0d", mode, phase, p);
      end
    end
    tick_edge();
    total++;
    if ({mode, phase, busy} !== 5'b0) begin
      bad++;
      $display("FAIL release_off got=%b exp=%b", {mode, phase, busy}, 5'b0);
    end
  endtask
  task automatic test_conflict();
    logic [1:0] exp;
`ifdef HAZARD_EN
    exp = 2'd3;
`else
    exp = 2'd0;
`endif
    turn_left = 1;
    turn_right = 1;
    tick_edge();
    tick_edge();
    total++;
    if (mode !== exp) begin
      bad++;
      $display("FAIL conflict_mode got=%0d exp=%0d", mode, exp);
    end
    turn_left = 0;
    turn_right = 0;
    repeat (4) tick_edge();
    total++;
    if (mode !== 2'd0) begin
      bad++;
      $display("FAIL conflict_clear got=%0d exp=0", mode);
    end
  endtask
  task automatic test_switch();
    turn_left = 1;
    tick_edge();
    tick_edge();
    total++;
    if (mode !== 2'd1 || phase !== 2'd0) begin
      bad++;
      $display("FAIL switch_left got=mode%0d phase%0d exp=mode1 phase0", mode, phase);
    end
    tick_edge();
    tick_edge();
    turn_left = 0;
    turn_right = 1;
    tick_edge();
    total++;
    if (mode !== 2'd1 || phase !== 2'd3) begin
      bad++;
      $display("FAIL switch_hold got=mode%0d phase%0d exp=mode1 phase3", mode, phase);
    end
    tick_edge();
    total++;
    if (mode !== 2'd2 || phase !== 2'd0) begin
      bad++;
      $display("FAIL switch_right got=mode%0d phase%0d exp=mode2 phase0", mode, phase);
    end
  endtask
  task automatic test_brake();
    brake = 1;
    repeat (4) step();
    total++;
    if (brake_active !== 1'b0) begin
      bad++;
      $display("FAIL brake_early got=%b exp=0", brake_active);
    end
    step();
    total++;
    if ({brake_active, mode, phase} !== {1'b1, 2'd2, 2'd1}) begin
      bad++;
      $display("FAIL brake_rise got=%b exp=%b", {brake_active, mode, phase}, {1'b1, 2'd2, 2'd1});
    end
    brake = 0;
    repeat (4) step();
    total++;
    if (brake_active !== 1'b1) begin
      bad++;
      $display("FAIL brake_hold got=%b exp=1", brake_active);
    end
    step();
    total++;
    if ({brake_active, mode, phase} !== {1'b0, 2'd2, 2'd2}) begin
      bad++;
      $display("FAIL brake_fall got=%b exp=%b", {brake_active, mode, phase}, {1'b0, 2'd2, 2'd2});
    end
  endtask
  task automatic test_reset_mid();
    turn_right = 0;
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    total++;
    if ({mode, phase, step_tick, brake_active, busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_async got=%b exp=%b", {mode, phase, step_tick, brake_active, busy}, 7'b0);
    end
    step();
    rst_n = 1;
    repeat (4) step();
    total++;
    if (step_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick_early got=%b exp=0", step_tick);
    end
    step();
    total++;
    if (step_tick !== 1'b1) begin
      bad++;
      $display("FAIL reset_tick_first got=%b exp=1", step_tick);
    end
  endtask
  initial begin
    test_reset();
    test_glitch();
    test_hold();
    test_release();
    test_conflict();
    test_switch();
    test_brake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
